// File: rtl/poly_note_ctrl.sv
// rtl/poly_note_ctrl.sv - polyphonic UART note controller; POLY_AUTO_RELEASE_EN adds ms-timed auto-release
module poly_note_ctrl #(
    parameter int C_CLK_FRQ    = 100_000_000,
    parameter int C_NOTE_MS    = 500,
    parameter int C_VOICES     = 4,
    parameter int C_NOTE_WIDTH = 7,
    parameter int C_ERR_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             UART_valid,
    input  logic [C_NOTE_WIDTH:0]            UART_msg,
    input  logic                             UART_err,
    output logic                             ack,
    output logic [C_VOICES-1:0]              voiceOn,
    output logic [C_VOICES*C_NOTE_WIDTH-1:0] voiceNote,
    output logic                             stolen,
    output logic [C_ERR_WIDTH-1:0]           errCnt
);

    localparam int PTR_W = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;

    if (C_VOICES < 1 || C_VOICES > 16 || C_NOTE_MS < 1 || C_CLK_FRQ < 1000
        || C_NOTE_WIDTH < 1 || C_ERR_WIDTH < 1) begin : gParamCheck
        $error("poly_note_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        EXEC  = 2'd2
    } stateType;

    stateType                  state;
    logic [C_NOTE_WIDTH:0]     msgReg;
    logic                      errReg;
    logic [PTR_W-1:0]          stealPtr;

    logic                      isOn;
    logic                      isAllOff;
    logic                      execOk;
    logic [C_NOTE_WIDTH-1:0]   cmdNote;
    logic [C_VOICES-1:0]       matchVec;
    logic                      anyFree;
    logic [PTR_W-1:0]          freeIdx;
    logic [PTR_W-1:0]          targetIdx;
    logic [C_VOICES-1:0]       retrigVec;
    logic [C_VOICES-1:0]       allocVec;
    logic [C_VOICES-1:0]       offVec;
    logic [C_VOICES-1:0]       expireVec;
    logic [C_VOICES-1:0]       nextOn;
    logic                      doSteal;

    // Command decode and voice allocation work on the registered gates, so a
    // voice expiring in the same cycle is still considered busy.
    always_comb begin
        isOn      = msgReg[C_NOTE_WIDTH];
        cmdNote   = msgReg[C_NOTE_WIDTH-1:0];
        isAllOff  = (msgReg == '0);
        execOk    = (state == EXEC) && !errReg;
        matchVec  = '0;
        anyFree   = 1'b0;
        freeIdx   = '0;
        targetIdx = '0;
        retrigVec = '0;
        allocVec  = '0;
        offVec    = '0;
        doSteal   = 1'b0;
        for (int v = 0; v < C_VOICES; v++) begin
            matchVec[v] = voiceOn[v]
                && (voiceNote[v*C_NOTE_WIDTH +: C_NOTE_WIDTH] == cmdNote);
        end
        for (int v = C_VOICES - 1; v >= 0; v--) begin
            if (!voiceOn[v]) begin
                anyFree = 1'b1;
                freeIdx = PTR_W'(v);
            end
        end
        targetIdx = anyFree ? freeIdx : stealPtr;
        if (execOk) begin
            if (isOn) begin
                if (|matchVec) begin
                    retrigVec = matchVec;
                end else begin
                    doSteal = !anyFree;
                    for (int v = 0; v < C_VOICES; v++) begin
                        allocVec[v] = (PTR_W'(v) == targetIdx);
                    end
                end
            end else if (isAllOff) begin
                offVec = '1;
            end else begin
                offVec = matchVec;
            end
        end
        // A load or retrigger on a voice overrides its expiry in the same cycle.
        nextOn = (voiceOn & ~expireVec & ~offVec) | retrigVec | allocVec;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            msgReg    <= '0;
            errReg    <= 1'b0;
            ack       <= 1'b0;
            stolen    <= 1'b0;
            errCnt    <= '0;
            stealPtr  <= '0;
            voiceOn   <= '0;
            voiceNote <= '0;
        end else begin
            ack     <= 1'b0;
            stolen  <= 1'b0;
            voiceOn <= nextOn;
            case (state)
                IDLE: begin
                    if (UART_valid) begin
                        msgReg <= UART_msg;
                        errReg <= UART_err;
                        ack    <= 1'b1;
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    if (errReg && (errCnt != '1)) begin
                        errCnt <= errCnt + 1'b1;
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    for (int v = 0; v < C_VOICES; v++) begin
                        if (allocVec[v]) begin
                            voiceNote[v*C_NOTE_WIDTH +: C_NOTE_WIDTH] <= cmdNote;
                        end
                    end
                    if (doSteal) begin
                        stolen <= 1'b1;
                        if (stealPtr == PTR_W'(C_VOICES - 1)) begin
                            stealPtr <= '0;
                        end else begin
                            stealPtr <= stealPtr + 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POLY_AUTO_RELEASE_EN
    localparam int PRE_MAX = C_CLK_FRQ / 1000 - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
    localparam int CNT_W   = $clog2(C_NOTE_MS + 1);

    logic [PRE_W-1:0]    preCnt;
    logic                msTick;
    logic [CNT_W-1:0]    msCnt [C_VOICES];
    logic [C_VOICES-1:0] timerClr;

    assign timerClr = retrigVec | allocVec;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            preCnt <= '0;
            msTick <= 1'b0;
        end else if (preCnt == PRE_W'(PRE_MAX)) begin
            preCnt <= '0;
            msTick <= 1'b1;
        end else begin
            preCnt <= preCnt + 1'b1;
            msTick <= 1'b0;
        end
    end

    // Counters saturate at C_NOTE_MS; the gate drops the cycle after they get there.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int v = 0; v < C_VOICES; v++) begin
                msCnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < C_VOICES; v++) begin
                if (timerClr[v]) begin
                    msCnt[v] <= '0;
                end else if (msTick && voiceOn[v] && (msCnt[v] != CNT_W'(C_NOTE_MS))) begin
                    msCnt[v] <= msCnt[v] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        expireVec = '0;
        for (int v = 0; v < C_VOICES; v++) begin
            expireVec[v] = voiceOn[v] && (msCnt[v] == CNT_W'(C_NOTE_MS));
        end
    end
`else
    assign expireVec = '0;
`endif

endmodule

// File: tb/tb_poly_note_ctrl.sv
// tb/tb_poly_note_ctrl.sv - scoreboard bench for poly_note_ctrl (directed byte vectors)
module tb_poly_note_ctrl;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        UART_valid = 1'b0;
    logic [7:0]  UART_msg = '0;
    logic        UART_err = 1'b0;
    logic        ack;
    logic [3:0]  voiceOn;
    logic [27:0] voiceNote;
    logic        stolen;
    logic [7:0]  errCnt;

    int total = 0;
    int bad   = 0;
    int lastLat = 0;

    typedef struct packed {
        logic [3:0]  on;
        logic [27:0] notes;
        logic        st;
        logic [7:0]  err;
    } expT;

    expT expQ[$];

    poly_note_ctrl #(
        .C_CLK_FRQ   (1_000_000),
        .C_NOTE_MS   (5),
        .C_VOICES    (4),
        .C_NOTE_WIDTH(7),
        .C_ERR_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .UART_valid(UART_valid),
        .UART_msg  (UART_msg),
        .UART_err  (UART_err),
        .ack       (ack),
        .voiceOn   (voiceOn),
        .voiceNote (voiceNote),
        .stolen    (stolen),
        .errCnt    (errCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each ack starts a response; state is checked two cycles later.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (rstb && ack) begin
                @(negedge clk);
                chk("ack_width", {31'd0, ack}, 32'd0);
                @(negedge clk);
                if (expQ.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("voiceOn", {28'd0, voiceOn}, {28'd0, e.on});
                    chk("voiceNote", {4'd0, voiceNote}, {4'd0, e.notes});
                    chk("stolen", {31'd0, stolen}, {31'd0, e.st});
                    chk("errCnt", {24'd0, errCnt}, {24'd0, e.err});
                end
            end
        end
    end

    task automatic sendByte(input logic [7:0] m, input logic e, input logic [3:0] eOn,
                            input logic [27:0] eNotes, input logic eSt, input logic [7:0] eErr);
        int n;
        expQ.push_back('{on: eOn, notes: eNotes, st: eSt, err: eErr});
        UART_msg   = m;
        UART_err   = e;
        UART_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        lastLat = n;
        if (!ack) chk("ack_timeout", 32'd0, 32'd1);
        UART_valid = 1'b0;
        UART_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic expLate;
`ifdef POLY_AUTO_RELEASE_EN
        expLate = 1'b0;
`else
        expLate = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_voiceOn", {28'd0, voiceOn}, 32'd0);
        chk("rst_voiceNote", {4'd0, voiceNote}, 32'd0);
        chk("rst_errCnt", {24'd0, errCnt}, 32'd0);

        // T1: first note-on goes to voice 0, ack one cycle after sampling
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3C}, 1'b0, 8'd0);
        chk("t1_ack_latency", lastLat, 32'd1);
        sendByte(8'h00, 1'b0, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3C}, 1'b0, 8'd0);

        // T2: fill all voices, then steal voice 0 and voice 1 in order
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3C}, 1'b0, 8'd0);
        sendByte(8'hC0, 1'b0, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3C}, 1'b0, 8'd0);
        sendByte(8'hC4, 1'b0, 4'b0111, {7'h00, 7'h44, 7'h40, 7'h3C}, 1'b0, 8'd0);
        sendByte(8'hC7, 1'b0, 4'b1111, {7'h47, 7'h44, 7'h40, 7'h3C}, 1'b0, 8'd0);
        sendByte(8'hC8, 1'b0, 4'b1111, {7'h47, 7'h44, 7'h40, 7'h48}, 1'b1, 8'd0);
        sendByte(8'hC9, 1'b0, 4'b1111, {7'h47, 7'h44, 7'h49, 7'h48}, 1'b1, 8'd0);
        sendByte(8'h3C, 1'b0, 4'b1111, {7'h47, 7'h44, 7'h49, 7'h48}, 1'b0, 8'd0);
        sendByte(8'h44, 1'b0, 4'b1011, {7'h47, 7'h44, 7'h49, 7'h48}, 1'b0, 8'd0);
        sendByte(8'hBD, 1'b0, 4'b1111, {7'h47, 7'h3D, 7'h49, 7'h48}, 1'b0, 8'd0);
        sendByte(8'h00, 1'b0, 4'b0000, {7'h47, 7'h3D, 7'h49, 7'h48}, 1'b0, 8'd0);

        // T3: note-off clears, unmatched note-off is a no-op
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd0);
        sendByte(8'h3C, 1'b0, 4'b0000, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd0);
        sendByte(8'h3D, 1'b0, 4'b0000, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd0);

        // T4: retrigger after 3 ms extends the note
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd0);
        repeat (3000) @(negedge clk);
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd0);
        repeat (3800) @(negedge clk);
        chk("t4_held_past_5ms", {31'd0, voiceOn[0]}, 32'd1);
        repeat (1300) @(negedge clk);
        chk("t4_release", {31'd0, voiceOn[0]}, {31'd0, expLate});

        // T5: errored bytes are counted, saturate, change no voice
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd0);
        for (int k = 0; k < 260; k++) begin
            sendByte(8'hC5, 1'b1, 4'b0001, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0,
                     (k + 1 > 255) ? 8'd255 : 8'(k + 1));
        end
        sendByte(8'h00, 1'b0, 4'b0000, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd255);

        // T6: reset while the byte is in LATCH
        sendByte(8'hBC, 1'b0, 4'b0001, {7'h47, 7'h3D, 7'h49, 7'h3C}, 1'b0, 8'd255);
        UART_msg   = 8'hC1;
        UART_valid = 1'b1;
        @(posedge clk);
        #1 rstb = 1'b0;
        #1;
        chk("t6_ack", {31'd0, ack}, 32'd0);
        chk("t6_voiceOn", {28'd0, voiceOn}, 32'd0);
        chk("t6_voiceNote", {4'd0, voiceNote}, 32'd0);
        chk("t6_stolen", {31'd0, stolen}, 32'd0);
        chk("t6_errCnt", {24'd0, errCnt}, 32'd0);
        @(negedge clk);
        UART_valid = 1'b0;
        rstb = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_byte_lost", {28'd0, voiceOn}, 32'd0);
        sendByte(8'hC1, 1'b0, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h41}, 1'b0, 8'd0);
        repeat (11000) @(negedge clk);
        chk("t6_hold_10ms", {31'd0, voiceOn[0]}, {31'd0, expLate});

        repeat (5) @(negedge clk);
        chk("queue_empty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
